// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: burst encodings and the arbiter FSM state type.
package cpu_bus_pkg;

  localparam logic [1:0] BURST_NORMAL = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] BURST_WRAP   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GNT_I  = 3'd1,
    ST_GNT_D  = 3'd2,
    ST_WAIT_I = 3'd3,
    ST_WAIT_D = 3'd4
  } arb_state_e;

endpackage

// File: rtl/arb_timeout.sv
// Saturating slave-response timeout counter.
// expire is asserted in the enabled cycle whose increment reaches TIMEOUT_CYC.
module arb_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles, clear on acceptance, hold at the maximum.
  always_ff @(posedge clk) begin
    if (!rst)                         cnt_q <= '0;
    else if (clr)                     cnt_q <= '0;
    else if (en && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
  end

  assign expire = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/idbus_arbiter.sv
// Instruction/data master arbiter onto one shared memory slave port.
// Optional build macro: ARB_RR_EN -- round-robin between I and D when both
// request in IDLE; otherwise D always wins.
module idbus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  // I master
  input  logic [ADDR_W-1:0]   IADDR,
  input  logic [1:0]          IBURST,
  input  logic                IREQ,
  input  logic                IWRB,
  input  logic [DATA_W-1:0]   IWDATA,
  input  logic [DATA_W/8-1:0] IBSTROBE,
  output logic [DATA_W-1:0]   IRDATA,
  output logic                IACK,
  output logic                ISTALL,
  // D master
  input  logic [ADDR_W-1:0]   DADDR,
  input  logic [1:0]          DBURST,
  input  logic                DREQ,
  input  logic                DWRB,
  input  logic [DATA_W-1:0]   DWDATA,
  input  logic [DATA_W/8-1:0] DBSTROBE,
  output logic [DATA_W-1:0]   DRDATA,
  output logic                DACK,
  output logic                DSTALL,
  // Slave
  output logic [ADDR_W-1:0]   MADDR,
  output logic [1:0]          MBURST,
  output logic                MREQ,
  output logic                MWRB,
  output logic [DATA_W-1:0]   MWDATA,
  output logic [DATA_W/8-1:0] MBSTROBE,
  input  logic [DATA_W-1:0]   MRDATA,
  input  logic                MACK,
  input  logic                MSTALL,
  // Status
  output logic                bus_err,
  output logic                gnt_d
);

  import cpu_bus_pkg::*;

  arb_state_e        state_q, state_d;
  logic              idle_sel_d, sel_d, in_gnt, in_wait, req_sel;
  logic              accept, expire, resp, tmo;
  logic [DATA_W-1:0] rdata_w, irdata_q, drdata_q;

`ifdef ARB_RR_EN
  logic rr_q;  // 1: D was granted last, so I wins the next tie

  // Remember which master won the last IDLE grant.
  always_ff @(posedge clk) begin
    if (!rst)                                rr_q <= 1'b0;
    else if ((state_q == ST_IDLE) && (DREQ || IREQ)) rr_q <= idle_sel_d;
  end

  assign idle_sel_d = DREQ && (!IREQ || !rr_q);
`else
  assign idle_sel_d = DREQ;
`endif

  // Ownership and handshake qualifiers; everything is quiet while in reset.
  assign sel_d   = (state_q == ST_GNT_D) || (state_q == ST_WAIT_D) ||
                   ((state_q == ST_IDLE) && idle_sel_d);
  assign in_gnt  = rst && ((state_q == ST_GNT_I) || (state_q == ST_GNT_D) ||
                           ((state_q == ST_IDLE) && (DREQ || IREQ)));
  assign in_wait = rst && ((state_q == ST_WAIT_I) || (state_q == ST_WAIT_D));
  assign req_sel = sel_d ? DREQ : IREQ;
  assign accept  = in_gnt && req_sel && !MSTALL;
  assign tmo     = in_wait && expire && !MACK;
  assign resp    = in_wait && (MACK || expire);
  assign rdata_w = tmo ? '0 : MRDATA;

  arb_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (in_wait),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: IDLE grants in the same cycle, so an unstalled request goes straight to WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (DREQ || IREQ) begin
          if (accept) state_d = idle_sel_d ? ST_WAIT_D : ST_WAIT_I;
          else        state_d = idle_sel_d ? ST_GNT_D  : ST_GNT_I;
        end
      ST_GNT_I:
        if (!IREQ)        state_d = ST_IDLE;
        else if (!MSTALL) state_d = ST_WAIT_I;
      ST_GNT_D:
        if (!DREQ)        state_d = ST_IDLE;
        else if (!MSTALL) state_d = ST_WAIT_D;
      ST_WAIT_I:
        if (MACK)   state_d = ((IBURST != BURST_NORMAL) && IREQ) ? ST_GNT_I : ST_IDLE;
        else if (expire) state_d = ST_IDLE;
      ST_WAIT_D:
        if (MACK)   state_d = ((DBURST != BURST_NORMAL) && DREQ) ? ST_GNT_D : ST_IDLE;
        else if (expire) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Held read data: track the live response while waiting, keep it afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      if (state_q == ST_WAIT_I) irdata_q <= rdata_w;
      if (state_q == ST_WAIT_D) drdata_q <= rdata_w;
    end
  end

  // Output decode: slave mux, stalls, acks and routed read data.
  always_comb begin
    MADDR    = sel_d ? DADDR    : IADDR;
    MBURST   = sel_d ? DBURST   : IBURST;
    MWRB     = sel_d ? DWRB     : IWRB;
    MWDATA   = sel_d ? DWDATA   : IWDATA;
    MBSTROBE = sel_d ? DBSTROBE : IBSTROBE;
    MREQ     = in_gnt && req_sel;
    ISTALL   = (in_gnt && !sel_d) ? MSTALL : 1'b1;
    DSTALL   = (in_gnt &&  sel_d) ? MSTALL : 1'b1;
    IACK     = resp && !sel_d;
    DACK     = resp &&  sel_d;
    IRDATA   = (in_wait && !sel_d) ? rdata_w : irdata_q;
    DRDATA   = (in_wait &&  sel_d) ? rdata_w : drdata_q;
    bus_err  = tmo;
    gnt_d    = rst && sel_d && (in_wait || (in_gnt && ((state_q != ST_IDLE) || DREQ)));
  end

endmodule

// File: doc/idbus_arbiter.md
IDBUS_ARBITER -- requirements
Module: idbus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum cycles from slave acceptance to ACK.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 I master port (from CPU): IADDR in ADDR_W; IBURST in 2; IREQ in 1; IWRB in 1; IWDATA in DATA_W; IBSTROBE in DATA_W/8; IRDATA out DATA_W; IACK out 1; ISTALL out 1.
REQ-007 D master port (from CPU): DADDR, DBURST, DREQ, DWRB, DWDATA, DBSTROBE, DRDATA, DACK, DSTALL; same directions and widths as REQ-006.
REQ-008 Shared slave port to memory: MADDR out ADDR_W; MBURST out 2; MREQ out 1; MWRB out 1; MWDATA out DATA_W; MBSTROBE out DATA_W/8; MRDATA in DATA_W; MACK in 1; MSTALL in 1.
REQ-009 bus_err  out  1  one-cycle pulse on slave timeout.
REQ-010 gnt_d  out  1  high while the D port owns the slave port.

Function
REQ-011 Transfer accepted on a port when REQ=1 and STALL=0 in the same cycle; completion is the cycle ACK=1; one outstanding transfer per master.
REQ-012 FSM states: IDLE, GNT_I, GNT_D, WAIT_I, WAIT_D.
REQ-013 IDLE: DREQ=1 -> GNT_D; else IREQ=1 -> GNT_I; same-cycle IDLE grant (combinational select), zero added latency.
REQ-014 GNT_x: selected master's address, control, write data and strobes drive the M* signals combinationally; MREQ=xREQ; xSTALL=MSTALL; the other master's STALL=1.
REQ-015 GNT_x with xREQ=1 and MSTALL=0 -> WAIT_x; timeout counter cleared.
REQ-016 WAIT_x: MREQ=0; both STALL=1; MRDATA routed to xRDATA; xACK=MACK; on MACK=1: xBURST!=2'b00 with xREQ still 1 -> GNT_x (burst lock), else -> IDLE.
REQ-017 Non-granted ACK is always 0; non-granted RDATA is held at its last value.
REQ-018 Timeout counter increments each WAIT_x cycle; reaching TIMEOUT_CYC without MACK -> pulse bus_err, pulse xACK with xRDATA=0, -> IDLE.
REQ-019 MACK outside WAIT_x is ignored; no state change.
REQ-020 Master dropping REQ in GNT_x before acceptance -> IDLE next cycle.
REQ-021 Counter width ceil(log2(TIMEOUT_CYC+1)); saturates, never wraps.

Reset
REQ-022 rst=0 at a clock edge: state IDLE, counter 0, RR pointer 0, bus_err 0, gnt_d 0, held RDATA 0.
REQ-023 While in reset: MREQ=0, IACK=DACK=0, ISTALL=DSTALL=1.
REQ-024 Reset mid-transfer abandons it; a late MACK after reset is ignored (REQ-019).

Configuration
REQ-025 Macro ARB_RR_EN defined: IDLE with both requests grants the master not granted last (pointer updates on every grant); pointer 0 after reset favours D.
REQ-026 Macro ARB_RR_EN undefined: fixed D-over-I priority per REQ-013; no pointer flop.

Structure
REQ-027 Package cpu_bus_pkg: burst encodings (NORMAL=2'b00, INCR=2'b01, WRAP=2'b10) and the FSM state enum; shared with other bus blocks.
REQ-028 One sub-module arb_timeout: counter with clear, enable, expiry output.
REQ-029 Total RTL 120-400 lines; no clock or reset gating.

Verification
REQ-030 IREQ=1, DREQ=1 in IDLE, MSTALL=0 -> D granted first (MADDR=DADDR); ISTALL=1 until DACK, then I served.
REQ-031 ARB_RR_EN defined, both requesting for 4 back-to-back transfers -> grant order D,I,D,I.
REQ-032 DREQ=1, DBURST=2'b01 for 4 beats, IREQ=1 throughout -> 4 D beats without I grant; I granted after the 4th DACK once DREQ drops.
REQ-033 TIMEOUT_CYC=8, no MACK after acceptance -> bus_err and DACK pulse at the 8th WAIT cycle, DRDATA=0, state IDLE.
REQ-034 rst=0 during WAIT_I, then MACK=1 after release -> IACK stays 0, MREQ=0, ISTALL=1 during reset.
REQ-035 MSTALL=1 for 3 cycles during GNT_I -> ISTALL mirrors MSTALL, MADDR stable, single acceptance on cycle 4.
